// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - op codes and state encoding shared by the multiply/divide unit
package alu_mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one restoring radix-2 division step (trial subtract and select)
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so the shifted value is below 2*divisor and the
    // restored remainder always fits in WIDTH bits.
    always_comb begin
        shifted = {rem, bit_in};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - iterative multiply/divide unit with architectural HI/LO registers
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic               dz;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Divide: acc holds {remainder, dividend bits shifting into quotient}.
    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem     (acc[2*WIDTH-1:WIDTH]),
        .bit_in  (acc[WIDTH-1]),
        .divisor (opb),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    always_comb begin
        div_next = {div_rem, acc[WIDTH-2:0], div_qbit};
        prod_fix = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
        quot_fix = (is_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            acc       <= '0;
            opb       <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (cancel) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            case (op)
                                MDU_MTHI: hi <= a;
                                MDU_MTLO: lo <= a;
                                MDU_MULT, MDU_MULTU: begin
                                    state     <= ST_MUL;
                                    busy      <= 1'b1;
                                    is_div    <= 1'b0;
                                    is_signed <= op_signed;
                                    sign_a    <= op_signed & a[WIDTH-1];
                                    sign_b    <= op_signed & b[WIDTH-1];
                                    acc       <= {{WIDTH{1'b0}}, b_mag};
                                    opb       <= a_mag;
                                    cnt       <= CNT_W'(WIDTH);
                                    dz        <= 1'b0;
                                end
                                MDU_DIV, MDU_DIVU: begin
                                    state     <= (b == '0) ? ST_FIX : ST_DIV;
                                    busy      <= 1'b1;
                                    is_div    <= 1'b1;
                                    is_signed <= op_signed;
                                    sign_a    <= op_signed & a[WIDTH-1];
                                    sign_b    <= op_signed & b[WIDTH-1];
                                    acc       <= {{WIDTH{1'b0}}, a_mag};
                                    opb       <= b_mag;
                                    cnt       <= CNT_W'(WIDTH);
                                    dz        <= (b == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                    ST_DIV: begin
                        acc <= div_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= dz;
                        // A zero divisor leaves HI/LO untouched; only the flag reports it.
                        if (!dz) begin
                            if (is_div) begin
                                hi <= rem_fix;
                                lo <= quot_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for the multiply/divide unit
module tb_alu_mdu;

    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam int LAT_FULL = W + 1;
    localparam int LAT_DZ   = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                checkb({mon_e.name, "_div_zero"}, div_zero, mon_e.dz);
                check({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic run(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input bit push, input string name, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edz, input int lat);
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.name = name;
            e.hi   = ehi;
            e.lo   = elo;
            e.dz   = edz;
            e.cyc  = cyc + 1 + lat;
            sb.push_back(e);
        end
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++)
            @(negedge clk);
        check({name, "_drain"}, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_done", done, 1'b0);
        checkb("rst_div_zero", div_zero, 1'b0);
        rst = 1'b0;

        run(OP_MULT, 32'hFFFFFFFF, 32'd2, 1, "mult_m1x2", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_FULL);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("mult_busy_cycles", n, 33);
        drain("mult_m1x2");

        run(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, "multu", 32'h00000001, 32'hFFFFFFFE, 1'b0, LAT_FULL);
        drain("multu");
        run(OP_DIVU, 32'd100, 32'd7, 1, "divu_100_7", 32'd2, 32'd14, 1'b0, LAT_FULL);
        drain("divu_100_7");
        run(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, "div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_FULL);
        drain("div_m7_2");
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, "div_ovf", 32'h0, 32'h80000000, 1'b0, LAT_FULL);
        drain("div_ovf");
        run(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, "div_7_m2", 32'd1, 32'hFFFFFFFD, 1'b0, LAT_FULL);
        drain("div_7_m2");
        run(OP_MULT, 32'hFFFFFFFD, 32'd5, 1, "mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT_FULL);
        drain("mult_m3x5");

        run(OP_MTHI, 32'h1234, 32'h0, 0, "", '0, '0, 1'b0, 0);
        run(OP_MTLO, 32'h5678, 32'h0, 0, "", '0, '0, 1'b0, 0);
        check("mthi_value", hi, 32'h1234);
        check("mtlo_value", lo, 32'h5678);
        checkb("mt_no_busy", busy, 1'b0);

        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hFFFF; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("idle_cancel_mthi", hi, 32'h1234);

        run(OP_DIV, 32'd5, 32'd0, 1, "div_zero", 32'h1234, 32'h5678, 1'b1, LAT_DZ);
        drain("div_zero");

        run(OP_MULT, 32'd3, 32'd5, 0, "", '0, '0, 1'b0, 0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkb("cancel_busy", busy, 1'b0);
        checkb("cancel_done", done, 1'b0);
        check("cancel_hi", hi, 32'h1234);
        check("cancel_lo", lo, 32'h5678);
        run(OP_MULTU, 32'd6, 32'd7, 1, "multu_after_cancel", 32'h0, 32'd42, 1'b0, LAT_FULL);
        drain("multu_after_cancel");

        run(OP_DIVU, 32'd1000, 32'd10, 1, "divu_busy_starts", 32'h0, 32'd100, 1'b0, LAT_FULL);
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd55; b = 32'd5;
        @(negedge clk);
        op = OP_MTLO; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        drain("divu_busy_starts");
        check("busy_mtlo_ignored", lo, 32'd100);

        run(OP_DIV, 32'd9, 32'd2, 0, "", '0, '0, 1'b0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        checkb("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkb("midrst_stays_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
